// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe
//   Registered RV32/RV64 decode stage that sits between instruction fetch and
//   register read. Each accepted instruction word is split into its register
//   indices, funct3 and opcode class. The stage also produces an XLEN-wide
//   sign-extended immediate and flags illegal encodings. A two-entry skid
//   arrangement (output register plus one skid entry) sustains one instruction
//   per cycle while in_ready comes straight from a flop.
//
// Parameters
//   XLEN   datapath width, 32 or 64; immediates are sign-extended to XLEN
//   CNT_W  width of the saturating decoded-instruction counter
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of every buffered and output entry
//   in_valid/in_ready   fetch-side handshake; in_ready is !skid_valid
//   in_instr, in_pc     instruction word and its PC
//   out_valid/out_ready read-side handshake
//   out_pc, out_imm     passed-through PC and decoded immediate
//   out_rd/rs1/rs2      register indices instr[11:7], [19:15], [24:20]
//   out_funct3          instr[14:12]
//   out_opclass         instr[6:2]
//   out_illegal         encoding not supported at this XLEN
//   dec_count           entries accepted downstream, saturating

module imm_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_opclass,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic [4:0] {
        OPC_LOAD      = 5'b00000,
        OPC_MISC_MEM  = 5'b00011,
        OPC_OP_IMM    = 5'b00100,
        OPC_AUIPC     = 5'b00101,
        OPC_OP_IMM_32 = 5'b00110,
        OPC_STORE     = 5'b01000,
        OPC_OP        = 5'b01100,
        OPC_LUI       = 5'b01101,
        OPC_OP_32     = 5'b01110,
        OPC_BRANCH    = 5'b11000,
        OPC_JALR      = 5'b11001,
        OPC_JAL       = 5'b11011,
        OPC_SYSTEM    = 5'b11100
    } opc_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [4:0]      opclass;
        logic            illegal;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Every immediate format is assembled as a signed 32-bit value and then
    // widened once, so the XLEN=64 case needs no per-format handling.
    function automatic entry_t decode(input logic [31:0] instr,
                                      input logic [XLEN-1:0] pc);
        entry_t             e;
        logic signed [31:0] imm32;
        logic               legal;
        // NOTE: every local gets a default before the case so that no path
        // leaves it unassigned; in combinational code a missing default is
        // what infers a latch.
        imm32 = '0;
        legal = 1'b1;
        case (instr[6:2])
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OPC_OP_IMM_32: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                legal = (XLEN == 64);
            end
            OPC_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            OPC_OP:
                imm32 = '0;
            OPC_OP_32:
                legal = (XLEN == 64);
            default:
                legal = 1'b0;
        endcase
        if (instr[1:0] != 2'b11) legal = 1'b0;

        e.pc      = pc;
        e.imm     = legal ? XLEN'(imm32) : '0;
        e.rd      = instr[11:7];
        e.rs1     = instr[19:15];
        e.rs2     = instr[24:20];
        e.funct3  = instr[14:12];
        e.opclass = instr[6:2];
        e.illegal = !legal;
        return e;
    endfunction

    entry_t in_dec;
    entry_t out_q;
    entry_t skid_q;
    logic   skid_valid;
    logic   accept;
    logic   out_load;

    assign in_dec   = decode(in_instr, in_pc);
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    // The output register may take a new entry when it is empty or its
    // current entry leaves this cycle.
    assign out_load = !out_valid || out_ready;

    // NOTE: all sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            dec_count  <= '0;
        end else begin
            // A transfer in the flush cycle has already left, so it counts.
            if (out_valid && out_ready && dec_count != CNT_MAX)
                dec_count <= dec_count + CNT_W'(1);

            if (flush) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (out_load) begin
                if (skid_valid) begin
                    // Older skid entry goes first; in_ready was low, so no
                    // input can arrive in the same cycle.
                    out_q      <= skid_q;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= accept;
                    if (accept) out_q <= in_dec;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
            end
        end
    end

    // NOTE: the skid payload has no reset; it is only ever read while
    // skid_valid is set, and skid_valid itself is reset.
    always_ff @(posedge clk) begin
        if (accept && !out_load) skid_q <= in_dec;
    end

    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_funct3  = out_q.funct3;
    assign out_opclass = out_q.opclass;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Self-checking bench for imm_decode_pipe. Two instances share all inputs:
// "a" is XLEN=32 with the default 16-bit counter, and "b" is XLEN=64 with a
// 3-bit counter so that saturation is reachable in a short run. A queue model
// of in-flight instructions, updated on every rising edge, predicts the
// handshake, the counters and the decoded fields. Outputs are compared on the
// falling edge.

module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_pc, a_out_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2, a_opclass;
    logic [2:0]  a_funct3;
    logic [15:0] a_dec_count;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_pc, b_out_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2, b_opclass;
    logic [2:0]  b_funct3;
    logic [2:0]  b_dec_count;

    imm_decode_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_imm(a_out_imm),
        .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_funct3(a_funct3), .out_opclass(a_opclass),
        .out_illegal(a_out_illegal), .dec_count(a_dec_count)
    );

    imm_decode_pipe #(.XLEN(64), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_imm(b_out_imm),
        .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_funct3(b_funct3), .out_opclass(b_opclass),
        .out_illegal(b_out_illegal), .dec_count(b_dec_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } txn_t;

    txn_t        q[$];
    int unsigned cnt_a = 0, cnt_b = 0;
    localparam int unsigned SAT_A = 65535;
    localparam int unsigned SAT_B = 7;

    // Immediate value computed as a plain integer from the format rules.
    function automatic void ref_decode(input logic [31:0] w, input int xlen,
                                       output logic [63:0] imm, output logic ill);
        longint v;
        bit     legal;
        v = 0;
        legal = 1'b1;
        case (w[6:2])
            5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100:
                v = longint'($signed(w[31:20]));
            5'b00110: begin
                v = longint'($signed(w[31:20]));
                legal = (xlen == 64);
            end
            5'b01000: v = longint'($signed({w[31:25], w[11:7]}));
            5'b11000: v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            5'b01101, 5'b00101: v = longint'($signed(w[31:12])) * 4096;
            5'b11011: v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            5'b01100: v = 0;
            5'b01110: legal = (xlen == 64);
            default:  legal = 1'b0;
        endcase
        if (w[1:0] != 2'b11) legal = 1'b0;
        if (!legal) v = 0;
        ill = !legal;
        imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    task automatic model_update();
        bit xfer, acc;
        if (!rst_n) begin
            q.delete();
            cnt_a = 0;
            cnt_b = 0;
            return;
        end
        xfer = (q.size() > 0) && out_ready;
        acc  = in_valid && (q.size() < 2);
        if (xfer) begin
            if (cnt_a < SAT_A) cnt_a++;
            if (cnt_b < SAT_B) cnt_b++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc) q.push_back('{in_instr, in_pc});
        end
    endtask

    task automatic compare();
        txn_t        h;
        logic [63:0] e_imm;
        logic        e_ill;
        check("in_ready_a", 64'(a_in_ready), 64'(q.size() < 2));
        check("in_ready_b", 64'(b_in_ready), 64'(q.size() < 2));
        check("out_valid_a", 64'(a_out_valid), 64'(q.size() > 0));
        check("out_valid_b", 64'(b_out_valid), 64'(q.size() > 0));
        check("dec_count_a", 64'(a_dec_count), 64'(cnt_a));
        check("dec_count_b", 64'(b_dec_count), 64'(cnt_b));
        if (q.size() > 0) begin
            h = q[0];
            ref_decode(h.instr, 32, e_imm, e_ill);
            check("pc_a", 64'(a_out_pc), {32'h0, h.pc[31:0]});
            check("imm_a", 64'(a_out_imm), e_imm);
            check("illegal_a", 64'(a_out_illegal), 64'(e_ill));
            check("rd_a", 64'(a_rd), 64'(h.instr[11:7]));
            check("rs1_a", 64'(a_rs1), 64'(h.instr[19:15]));
            check("rs2_a", 64'(a_rs2), 64'(h.instr[24:20]));
            check("funct3_a", 64'(a_funct3), 64'(h.instr[14:12]));
            check("opclass_a", 64'(a_opclass), 64'(h.instr[6:2]));
            ref_decode(h.instr, 64, e_imm, e_ill);
            check("pc_b", b_out_pc, h.pc);
            check("imm_b", b_out_imm, e_imm);
            check("illegal_b", 64'(b_out_illegal), 64'(e_ill));
            check("rd_b", 64'(b_rd), 64'(h.instr[11:7]));
        end
    endtask

    // One clock: the model follows the rising edge, outputs are compared
    // on the falling edge. Inputs are driven only while at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic        ill32;
        logic [63:0] imm64;
        logic        ill64;
    } vec_t;

    vec_t vecs[12];

    logic [4:0] legal_opcs[13] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101,
                                   5'b00110, 5'b01000, 5'b01100, 5'b01101,
                                   5'b01110, 5'b11000, 5'b11001, 5'b11011,
                                   5'b11100};

    initial begin
        logic [15:0] saved_a;
        logic [2:0]  saved_b;
        logic [31:0] w;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // ADDI -1
        vecs[1]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // JAL -4
        vecs[2]  = '{32'h123452B7, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0}; // LUI
        vecs[3]  = '{32'h00000000, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1}; // all zero
        vecs[4]  = '{32'h0000003B, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b0}; // OP_32
        vecs[5]  = '{32'hFE112C23, 32'hFFFFFFF8, 1'b0, 64'hFFFFFFFFFFFFFFF8, 1'b0}; // SW -8
        vecs[6]  = '{32'h80000063, 32'hFFFFF000, 1'b0, 64'hFFFFFFFFFFFFF000, 1'b0}; // BEQ min
        vecs[7]  = '{32'h8000001B, 32'h00000000, 1'b1, 64'hFFFFFFFFFFFFF800, 1'b0}; // OP_IMM_32
        vecs[8]  = '{32'hFFF00017, 32'hFFF00000, 1'b0, 64'hFFFFFFFFFFF00000, 1'b0}; // AUIPC
        vecs[9]  = '{32'hFFF00092, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1}; // bits[1:0]=10
        vecs[10] = '{32'hFFFFFF7F, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1}; // opcode 11111
        vecs[11] = '{32'hFFF00033, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0}; // OP

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        // Reset state, checked before any clock edge.
        #1;
        check("rst_out_valid_a", 64'(a_out_valid), 64'd0);
        check("rst_in_ready_a", 64'(a_in_ready), 64'd1);
        check("rst_dec_count_a", 64'(a_dec_count), 64'd0);
        check("rst_imm_a", 64'(a_out_imm), 64'd0);
        check("rst_pc_b", b_out_pc, 64'd0);
        check("rst_rd_b", 64'(b_rd), 64'd0);
        check("rst_out_valid_b", 64'(b_out_valid), 64'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // Table: one instruction at a time with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 64'h1000 + 64'(i * 4);
            cycle();
            in_valid = 1'b0;
            check($sformatf("tbl%0d_valid", i), 64'(a_out_valid), 64'd1);
            check($sformatf("tbl%0d_imm32", i), 64'(a_out_imm), 64'(vecs[i].imm32));
            check($sformatf("tbl%0d_ill32", i), 64'(a_out_illegal), 64'(vecs[i].ill32));
            check($sformatf("tbl%0d_imm64", i), b_out_imm, vecs[i].imm64);
            check($sformatf("tbl%0d_ill64", i), 64'(b_out_illegal), 64'(vecs[i].ill64));
            cycle();
            check($sformatf("tbl%0d_cnt", i), 64'(a_dec_count), 64'(i + 1));
        end

        // Back-to-back stream: JAL then LUI, one result per cycle.
        in_valid = 1'b1; in_instr = 32'hFFDFF06F; in_pc = 64'h200;
        cycle();
        in_instr = 32'h123452B7; in_pc = 64'h204;
        check("b2b_imm0", 64'(a_out_imm), 64'hFFFFFFFC);
        cycle();
        in_valid = 1'b0;
        check("b2b_imm1", 64'(a_out_imm), 64'h12345000);
        check("b2b_valid1", 64'(a_out_valid), 64'd1);
        cycle();

        // Backpressure: three words offered while out_ready is low.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h300;
        cycle();
        in_instr = 32'h00200113; in_pc = 64'h304;
        cycle();
        check("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        in_instr = 32'h00300193; in_pc = 64'h308;
        cycle();
        check("bp_hold_pc", 64'(a_out_pc), 64'h300);
        check("bp_hold_rd", 64'(a_rd), 64'd1);
        out_ready = 1'b1;
        cycle();
        check("bp_drain_pc1", 64'(a_out_pc), 64'h304);
        check("bp_in_ready_back", 64'(a_in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        check("bp_third_pc", 64'(a_out_pc), 64'h308);
        cycle();

        // Flush with two entries buffered and out_ready low.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 64'h400;
        cycle();
        in_pc = 64'h404;
        cycle();
        saved_a = a_dec_count;
        flush = 1'b1; in_pc = 64'h408;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 64'(a_out_valid), 64'd0);
        check("fl_in_ready", 64'(a_in_ready), 64'd1);
        check("fl_count_same", 64'(a_dec_count), 64'(saved_a));

        // A transfer in the flush cycle still counts.
        in_valid = 1'b1; in_pc = 64'h40C;
        cycle();
        in_valid = 1'b0;
        saved_a = a_dec_count;
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_xfer_count", 64'(a_dec_count), 64'(saved_a + 16'd1));
        check("fl_xfer_valid", 64'(a_out_valid), 64'd0);

        // Asynchronous reset in the middle of a stream.
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h500;
        cycle();
        check("mid_valid_before", 64'(a_out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid_a", 64'(a_out_valid), 64'd0);
        check("mid_rst_count_a", 64'(a_dec_count), 64'd0);
        check("mid_rst_valid_b", 64'(b_out_valid), 64'd0);
        check("mid_rst_count_b", 64'(b_dec_count), 64'd0);
        in_valid = 1'b0;
        q.delete(); cnt_a = 0; cnt_b = 0;
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Randomised traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0)
                w = {w[31:7], legal_opcs[$urandom_range(0, 12)], 2'b11};
            in_instr  = w;
            in_pc     = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            cycle();
        end

        // Saturation of the 3-bit counter after a steady stream.
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            in_instr = 32'h00000013; in_pc = 64'(n);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        saved_b = b_dec_count;
        check("sat_count_b", 64'(saved_b), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
